// File: rtl/core_pipe_exec_mdu.sv
// core_pipe_exec_mdu: iterative RV64M/RV32M multiply/divide unit for the execute stage.
//
// Multiply is shift-add over MUL_UNROLL multiplier bits per cycle on absolute values,
// with the product negated on the last step. Divide is restoring division, one quotient
// bit per cycle, on absolute values with the sign fixed up on the last step.
// The result is registered and held in DONE until mdu_ack; mdu_flush aborts from any state.
//
// Optional feature macro: CORE_MDU_FASTPATH_EN
//   defined   : div-by-zero, signed overflow and multiply-by-zero finish straight from IDLE;
//               divide also skips 8 leading zero dividend bits per cycle.
//   undefined : every op takes the full N+1 cycles.
//
// Ports:
//   g_clk, g_resetn         clock, asynchronous active-low reset
//   mdu_valid               op present, held until mdu_ack or mdu_flush
//   mdu_op[2:0]             MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   mdu_word                W variant (32-bit operation, sign-extended result)
//   mdu_opr_a, mdu_opr_b    rs1 / rs2
//   mdu_flush               abort current op
//   mdu_ack                 result consumed
//   mdu_ready               result valid (DONE)
//   mdu_result              registered result
//   mdu_busy                iterating (MUL or DIV)
//
// state | meaning
// IDLE  | waiting for an op
// MUL   | shift-add multiply iterations
// DIV   | restoring divide iterations
// DONE  | result held until ack
module core_pipe_exec_mdu #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            mdu_valid,
  input  logic [2:0]      mdu_op,
  input  logic            mdu_word,
  input  logic [XLEN-1:0] mdu_opr_a,
  input  logic [XLEN-1:0] mdu_opr_b,
  input  logic            mdu_flush,
  input  logic            mdu_ack,
  output logic            mdu_ready,
  output logic [XLEN-1:0] mdu_result,
  output logic            mdu_busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int U  = MUL_UNROLL;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic              neg_q, neg_d;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Operand conditioning on capture
  logic            a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b;

  always_comb begin
    a_sgn = (mdu_op == 3'd0) || (mdu_op == 3'd1) || (mdu_op == 3'd2) ||
            (mdu_op == 3'd4) || (mdu_op == 3'd6);
    b_sgn = (mdu_op == 3'd0) || (mdu_op == 3'd1) || (mdu_op == 3'd4) || (mdu_op == 3'd6);
    if (mdu_word) begin
      a_ext = a_sgn ? sext32(mdu_opr_a[31:0]) : XLEN'(mdu_opr_a[31:0]);
      b_ext = b_sgn ? sext32(mdu_opr_b[31:0]) : XLEN'(mdu_opr_b[31:0]);
    end else begin
      a_ext = mdu_opr_a;
      b_ext = mdu_opr_b;
    end
    sa    = a_sgn & a_ext[XLEN-1];
    sb    = b_sgn & b_ext[XLEN-1];
    abs_a = sa ? -a_ext : a_ext;
    abs_b = sb ? -b_ext : b_ext;
  end

  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
`ifdef CORE_MDU_FASTPATH_EN
  logic [XLEN-1:0] fast_raw;
  always_comb begin
    fast_hit = 1'b0;
    fast_raw = '0;
    if (mdu_op[2]) begin
      if (b_ext == '0) begin
        fast_hit = 1'b1;
        fast_raw = mdu_op[1] ? a_ext : '1;
      end else if (b_sgn && (b_ext == '1) &&
                   (a_ext == (mdu_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}))) begin
        fast_hit = 1'b1;
        fast_raw = mdu_op[1] ? '0 : a_ext;
      end
    end else if ((a_ext == '0) || (b_ext == '0)) begin
      fast_hit = 1'b1;
    end
    fast_res = mdu_word ? sext32(fast_raw[31:0]) : fast_raw;
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right by U
  logic [XLEN+U-1:0] mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_full;
  logic [31:0]       prod_w;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_sum = {{U{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    for (int i = 0; i < U; i++) begin
      if (acc_q[i]) mul_sum = mul_sum + ({{U{1'b0}}, opa_q} << i);
    end
    mul_next  = {mul_sum, acc_q[XLEN-1:U]};
    prod_full = neg_q ? -mul_next : mul_next;
    // After 32 steps the product's bit 0 sits at XLEN-32
    prod_w    = neg_q ? -mul_next[XLEN-1:XLEN-32] : mul_next[XLEN-1:XLEN-32];
    if (word_q)              mul_res = sext32(prod_w);
    else if (op_q[1:0] == 0) mul_res = prod_full[XLEN-1:0];
    else                     mul_res = prod_full[2*XLEN-1:XLEN];
  end

  // Divide step: acc = {remainder, dividend/quotient}, shifted left by 1
  logic [2*XLEN-1:0] div_sh, div_next;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   div_raw, div_res;

  always_comb begin
    div_sh   = {acc_q[2*XLEN-2:0], 1'b0};
    div_diff = {acc_q[2*XLEN-1], div_sh[2*XLEN-1:XLEN]} - {1'b0, opa_q};
    if (!div_diff[XLEN]) div_next = {div_diff[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
    else                 div_next = div_sh;
    div_raw = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    if (neg_q) div_raw = -div_raw;
    // Divide by zero: sign fix-up must not touch the all-ones quotient
    if (!op_q[1] && (opa_q == '0)) div_raw = '1;
    div_res = word_q ? sext32(div_raw[31:0]) : div_raw;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    res_d   = res_q;
    op_d    = op_q;
    word_d  = word_q;
    neg_d   = neg_q;
    if (mdu_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu_valid) begin
            op_d   = mdu_op;
            word_d = mdu_word;
            if (fast_hit) begin
              res_d   = fast_res;
              state_d = DONE;
            end else if (mdu_op[2]) begin
              opa_d   = abs_b;
              acc_d   = {{XLEN{1'b0}}, (mdu_word ? (abs_a << (XLEN-32)) : abs_a)};
              cnt_d   = mdu_word ? CW'(31) : CW'(XLEN-1);
              neg_d   = mdu_op[1] ? sa : (sa ^ sb);
              state_d = DIV;
            end else begin
              opa_d   = abs_a;
              acc_d   = {{XLEN{1'b0}}, abs_b};
              cnt_d   = mdu_word ? CW'(32/U - 1) : CW'(XLEN/U - 1);
              neg_d   = sa ^ sb;
              state_d = MUL;
            end
          end
        end
        MUL: begin
          acc_d = mul_next;
          if (cnt_q == '0) begin
            res_d   = mul_res;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DIV: begin
`ifdef CORE_MDU_FASTPATH_EN
          if ((acc_q[2*XLEN-1:XLEN] == '0) && (acc_q[XLEN-1:XLEN-8] == '0) && (cnt_q >= CW'(8))) begin
            acc_d = acc_q << 8;
            cnt_d = cnt_q - CW'(8);
          end else
`endif
          begin
            acc_d = div_next;
            if (cnt_q == '0) begin
              res_d   = div_res;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        DONE: begin
          if (mdu_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      res_q   <= res_d;
      op_q    <= op_d;
      word_q  <= word_d;
      neg_q   <= neg_d;
    end
  end

  assign mdu_ready  = (state_q == DONE);
  assign mdu_busy   = (state_q == MUL) || (state_q == DIV);
  assign mdu_result = res_q;

`ifndef SYNTHESIS
  a_valid_held: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (((state_q == MUL) || (state_q == DIV)) && !mdu_flush) |-> mdu_valid)
    else $error("mdu_valid dropped while iterating");
`endif

endmodule
